// File: rtl/fip_32_cramer_seq.sv
// fip_32_cramer_seq: sequenced Q16.16 3x3 Cramer's-rule solver sharing one det and one div unit
module fip_32_3b3_det (
  input  logic [31:0] i_m [2:0][2:0],
  output logic [31:0] o_det,
  output logic        o_overflow
);
  function automatic logic signed [63:0] qmul(input logic signed [31:0] x, input logic signed [31:0] y);
    return (64'(x) * 64'(y)) >>> 16;
  endfunction
  function automatic logic fits(input logic signed [63:0] v);
    return v[63:31] == {33{v[31]}};
  endfunction
  logic signed [63:0] pa [3];
  logic signed [63:0] pb [3];
  logic signed [63:0] mn [3];
  logic signed [63:0] t [3];
  logic signed [63:0] acc;
  logic [2:0] ov;
  for (genvar c = 0; c < 3; c++) begin : g_cof
    localparam int C1 = (c + 1) % 3;
    localparam int C2 = (c + 2) % 3;
    assign pa[c] = qmul(i_m[1][C1], i_m[2][C2]);
    assign pb[c] = qmul(i_m[1][C2], i_m[2][C1]);
    assign mn[c] = pa[c] - pb[c];
    assign t[c]  = qmul(i_m[0][c], mn[c][31:0]);
    assign ov[c] = !fits(pa[c]) || !fits(pb[c]) || !fits(mn[c]) || !fits(t[c]);
  end
  assign acc        = t[0] + t[1] + t[2];
  assign o_det      = acc[31:0];
  assign o_overflow = |ov || !fits(acc);
endmodule

module fip_32_div (
  input  logic [31:0] i_num,
  input  logic [31:0] i_den,
  output logic [31:0] o_q,
  output logic        o_overflow,
  output logic        o_underflow
);
  logic signed [63:0] n, d, q;
  assign n           = {{16{i_num[31]}}, i_num, 16'h0};
  assign d           = {{32{i_den[31]}}, i_den};
  assign q           = (d == 64'sd0) ? 64'sd0 : n / d;
  assign o_q         = q[31:0];
  assign o_underflow = d == 64'sd0;
  assign o_overflow  = q[63:31] != {33{q[31]}};
endmodule

module fip_32_cramer_seq #(
  parameter int FRAC_BITS     = 16,
  parameter int SKIP_SINGULAR = 1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_a [2:0][2:0],
  input  logic [31:0] i_b [2:0],
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_x [2:0],
  output logic [31:0] o_det,
  output logic        o_singular,
  output logic        o_overflow
);
  if (FRAC_BITS != 16) begin : g_frac_unsupported
    $error("shared det/div units are fixed at Q16.16");
  end
  typedef enum logic [1:0] {IDLE, DET, DIV, DONE} state_t;
  state_t state, nxt;
  logic [1:0]  cnt;
  logic [31:0] a_r [2:0][2:0];
  logic [31:0] b_r [2:0];
  logic [31:0] dm [2:0][2:0];
  logic [31:0] det_a;
  logic [31:0] det_k [2:0];
  logic [31:0] xs [1:0];
  logic [31:0] det_q, q;
  logic        det_ovf, div_ovf, div_unf;
  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign dm[r][c] = (cnt - 2'd1 == 2'(c)) ? b_r[r] : a_r[r][c];
    end
  end
  fip_32_3b3_det u_det (.i_m(dm), .o_det(det_q), .o_overflow(det_ovf));
  fip_32_div u_div (.i_num(det_k[cnt]), .i_den(det_a), .o_q(q), .o_overflow(div_ovf), .o_underflow(div_unf));
  assign o_ready = state == IDLE;
  assign o_valid = state == DONE;
  // next-state: four det passes, three div passes, singular systems may skip the divides
  always_comb begin
    nxt = state;
    if (state == IDLE && i_valid) nxt = DET;
    if (state == DET && cnt == 2'd3) nxt = (det_a == '0 && SKIP_SINGULAR != 0) ? DONE : DIV;
    if (state == DIV && cnt == 2'd2) nxt = DONE;
    if (state == DONE && i_ready) nxt = IDLE;
  end
  // datapath: capture system, register pass results, publish outputs only on DONE entry
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      a_r        <= '{default: '0};
      b_r        <= '{default: '0};
      det_a      <= '0;
      det_k      <= '{default: '0};
      xs         <= '{default: '0};
      o_x        <= '{default: '0};
      o_det      <= '0;
      o_singular <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? 2'd0 : cnt + 2'd1;
      if (o_ready && i_valid) begin
        a_r        <= i_a;
        b_r        <= i_b;
        o_singular <= 1'b0;
        o_overflow <= 1'b0;
      end
      if (state == DET) begin
        if (cnt == 2'd0) det_a <= det_q;
        else det_k[cnt - 2'd1] <= det_q;
        o_overflow <= o_overflow | det_ovf;
        if (cnt == 2'd3 && det_a == '0) begin
          o_singular <= 1'b1;
          if (SKIP_SINGULAR != 0) begin
            o_x   <= '{default: '0};
            o_det <= det_a;
          end
        end
      end
      if (state == DIV) begin
        o_overflow <= o_overflow | div_ovf | div_unf;
        if (cnt != 2'd2) xs[cnt[0]] <= q;
        else begin
          o_x[0] <= xs[0];
          o_x[1] <= xs[1];
          o_x[2] <= q;
          o_det  <= det_a;
        end
      end
    end
  end
endmodule

// File: tb/tb_fip_32_cramer_seq.sv
// tb_fip_32_cramer_seq: directed-vector bench for the sequenced Cramer solver
module tb_fip_32_cramer_seq;
  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_ready, o_valid, o_singular, o_overflow;
  logic [31:0] i_a [2:0][2:0];
  logic [31:0] i_b [2:0];
  logic [31:0] o_x [2:0];
  logic [31:0] o_det;
  int tests = 0;
  int fails = 0;
  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [31:0] BIG = 32'h7FFF_0000;
  always #5 i_clk = ~i_clk;
  fip_32_cramer_seq dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
    .o_x(o_x), .o_det(o_det), .o_singular(o_singular), .o_overflow(o_overflow)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic load(input logic [31:0] m [9], input logic [31:0] v [3]);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) i_a[r][c] = m[3*r+c];
      i_b[r] = v[r];
    end
  endtask
  task automatic accept(input string tag);
    @(negedge i_clk);
    chk({tag, "_rdy"}, 32'(o_ready), 1);
    i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
  endtask
  task automatic wait_valid(input string tag, input int lat);
    int n;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_valid && n < 40);
    chk({tag, "_lat"}, 32'(n), 32'(lat));
  endtask
  task automatic chk_out(input string tag, input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
                         input logic [31:0] det, input logic sing, input logic ovf);
    chk({tag, "_x0"}, o_x[0], x0);
    chk({tag, "_x1"}, o_x[1], x1);
    chk({tag, "_x2"}, o_x[2], x2);
    chk({tag, "_det"}, o_det, det);
    chk({tag, "_sing"}, 32'(o_singular), 32'(sing));
    chk({tag, "_ovf"}, 32'(o_overflow), 32'(ovf));
  endtask
  task automatic handoff(input string tag);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1 i_ready = 1'b0;
    chk({tag, "_vld_off"}, 32'(o_valid), 0);
    chk({tag, "_rdy_on"}, 32'(o_ready), 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    i_a = '{default: '0};
    i_b = '{default: '0};
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_vld", 32'(o_valid), 0);
    chk_out("rst", 0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    #1 chk("rst_rdy", 32'(o_ready), 1);
    load('{32'h0002_0000, 0, 0, 0, 32'h0004_0000, 0, 0, 0, 32'h0000_8000}, '{ONE, 32'h0002_0000, ONE});
    accept("diag");
    wait_valid("diag", 8);
    chk_out("diag", 32'h0000_8000, 32'h0000_8000, 32'h0002_0000, 32'h0004_0000, 0, 0);
    handoff("diag");
    load('{ONE, 0, 0, 0, ONE, 0, 0, 0, ONE}, '{ONE, 32'hFFFE_0000, 32'h0003_0000});
    accept("ident");
    wait_valid("ident", 8);
    chk_out("ident", ONE, 32'hFFFE_0000, 32'h0003_0000, ONE, 0, 0);
    handoff("ident");
    load('{ONE, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000, 32'h0006_0000,
           32'h0007_0000, 32'h0008_0000, 32'h0009_0000}, '{ONE, ONE, ONE});
    accept("sing");
    wait_valid("sing", 5);
    chk_out("sing", 0, 0, 0, 0, 1, 0);
    handoff("sing");
    load('{BIG, BIG, BIG, BIG, BIG, BIG, BIG, BIG, BIG}, '{ONE, ONE, ONE});
    accept("big");
    wait_valid("big", 5);
    chk("big_ovf", 32'(o_overflow), 1);
    chk("big_sing", 32'(o_singular), 1);
    handoff("big");
    load('{ONE, 0, 0, 0, ONE, 0, 0, 0, ONE}, '{ONE, 32'hFFFE_0000, 32'h0003_0000});
    accept("bp");
    wait_valid("bp", 8);
    for (int i = 0; i < 6; i++) begin
      i_valid = ~i_valid;
      i_a[0][0] = $urandom;
      i_a[1][2] = $urandom;
      @(negedge i_clk);
      chk("bp_rdy_low", 32'(o_ready), 0);
      chk("bp_x1_hold", o_x[1], 32'hFFFE_0000);
    end
    i_valid = 1'b0;
    chk_out("bp", ONE, 32'hFFFE_0000, 32'h0003_0000, ONE, 0, 0);
    handoff("bp");
    load('{ONE, 0, 0, 0, ONE, 0, 0, 0, ONE}, '{32'h0000_8000, 32'h0003_0000, 32'hFFFF_0000});
    accept("abort");
    repeat (3) @(negedge i_clk);
    #1 i_rstn = 1'b0;
    #1;
    chk("abort_vld", 32'(o_valid), 0);
    chk("abort_det", o_det, 0);
    chk("abort_x0", o_x[0], 0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    #1 chk("abort_rdy", 32'(o_ready), 1);
    accept("post");
    wait_valid("post", 8);
    chk_out("post", 32'h0000_8000, 32'h0003_0000, 32'hFFFF_0000, ONE, 0, 0);
    handoff("post");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
